// File: rtl/bus_demux_pkg.sv
// Shared bus widths and router FSM encodings for the single-master command/response demux.
package bus_demux_pkg;
  localparam int MEMBUS_W  = 32;
  localparam int MEMADDR_W = 32;
  localparam int MASK_W    = 4;
  localparam int IDX_W     = 4;

  localparam logic [1:0] ENC_IDLE    = 2'd0;
  localparam logic [1:0] ENC_RD_WAIT = 2'd1;
  localparam logic [1:0] ENC_WR_WAIT = 2'd2;
  localparam logic [1:0] ENC_ERR_RSP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = ENC_IDLE,
    ST_RD_WAIT = ENC_RD_WAIT,
    ST_WR_WAIT = ENC_WR_WAIT,
    ST_ERR_RSP = ENC_ERR_RSP
  } state_e;
endpackage

// File: rtl/bus_demux_dec.sv
// Address-field to slave-index decoder; flags whether the index names an existing slave.
module bus_demux_dec
  import bus_demux_pkg::*;
#(
  parameter int SLV_N = 4,
  parameter int FW    = 4
) (
  input  logic [FW-1:0]    i_field,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_mapped
);
  localparam logic [IDX_W:0] SLV_N_L = (IDX_W+1)'(SLV_N);

  assign o_idx    = IDX_W'(i_field);
  assign o_mapped = ({1'b0, o_idx} < SLV_N_L);
endmodule

// File: rtl/bus_demux.sv
// One-outstanding command router: forwards to the addressed slave, returns read data,
// swallows write responses and answers unmapped accesses with an error.
module bus_demux
  import bus_demux_pkg::*;
#(
  parameter int SLV_N  = 4,
  parameter int AW     = MEMADDR_W,
  parameter int DW     = MEMBUS_W,
  parameter int SEL_HI = 31,
  parameter int SEL_LO = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         m_cmd_wdata,
  input  logic [AW-1:0]         m_cmd_addr,
  input  logic                  m_cmd_we,
  input  logic [MASK_W-1:0]     m_cmd_wem,
  input  logic                  m_cmd_valid,
  output logic                  m_cmd_ready,
  output logic [DW-1:0]         m_rsp_rdata,
  output logic                  m_rsp_valid,
  input  logic                  m_rsp_ready,
  output logic                  m_rsp_error,
  output logic                  wr_err_o,
  output logic [SLV_N*DW-1:0]   s_cmd_wdata,
  output logic [SLV_N*AW-1:0]   s_cmd_addr,
  output logic [SLV_N-1:0]      s_cmd_we,
  output logic [SLV_N*MASK_W-1:0] s_cmd_wem,
  output logic [SLV_N-1:0]      s_cmd_valid,
  input  logic [SLV_N-1:0]      s_cmd_ready,
  input  logic [SLV_N*DW-1:0]   s_rsp_rdata,
  input  logic [SLV_N-1:0]      s_rsp_valid,
  output logic [SLV_N-1:0]      s_rsp_ready,
  input  logic [SLV_N-1:0]      s_rsp_error
);
  localparam int FW = SEL_HI - SEL_LO + 1;

  state_e             r_state;
  logic [IDX_W-1:0]   r_sel;
  logic [IDX_W-1:0]   w_idx;
  logic               w_mapped;
  logic               w_sel_rsp_vld;
  logic               w_sel_rsp_err;
  logic               w_cmd_hs;

  bus_demux_dec #(
    .SLV_N (SLV_N),
    .FW    (FW)
  ) u_dec (
    .i_field  (m_cmd_addr[SEL_HI:SEL_LO]),
    .o_idx    (w_idx),
    .o_mapped (w_mapped)
  );

  // Command fields go to every slot; only the valid bit is steered.
  assign s_cmd_wdata = {SLV_N{m_cmd_wdata}};
  assign s_cmd_addr  = {SLV_N{m_cmd_addr}};
  assign s_cmd_we    = {SLV_N{m_cmd_we}};
  assign s_cmd_wem   = {SLV_N{m_cmd_wem}};

  assign w_cmd_hs = (r_state == ST_IDLE) && m_cmd_valid && m_cmd_ready;

  always_comb begin
    s_cmd_valid   = '0;
    m_cmd_ready   = 1'b0;
    s_rsp_ready   = '0;
    m_rsp_valid   = 1'b0;
    m_rsp_rdata   = '0;
    m_rsp_error   = 1'b0;
    w_sel_rsp_vld = 1'b0;
    w_sel_rsp_err = 1'b0;
    for (int i = 0; i < SLV_N; i++) begin
      if (r_sel == IDX_W'(i)) begin
        w_sel_rsp_vld = s_rsp_valid[i];
        w_sel_rsp_err = s_rsp_error[i];
      end
    end
    case (r_state)
      ST_IDLE: begin
        if (w_mapped) begin
          for (int i = 0; i < SLV_N; i++) begin
            if (w_idx == IDX_W'(i)) begin
              s_cmd_valid[i] = m_cmd_valid;
              m_cmd_ready    = s_cmd_ready[i];
            end
          end
        end else begin
          m_cmd_ready = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        for (int i = 0; i < SLV_N; i++) begin
          if (r_sel == IDX_W'(i)) begin
            m_rsp_valid    = s_rsp_valid[i];
            m_rsp_rdata    = s_rsp_rdata[i*DW +: DW];
            m_rsp_error    = s_rsp_error[i];
            s_rsp_ready[i] = m_rsp_ready;
          end
        end
      end
      ST_WR_WAIT: begin
        for (int i = 0; i < SLV_N; i++) begin
          if (r_sel == IDX_W'(i)) s_rsp_ready[i] = 1'b1;
        end
      end
      ST_ERR_RSP: begin
        m_rsp_valid = 1'b1;
        m_rsp_error = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset masks the pulse so a write presented during reset cannot flag an error.
  assign wr_err_o = !rst &&
                    ((w_cmd_hs && m_cmd_we && !w_mapped) ||
                     (r_state == ST_WR_WAIT && w_sel_rsp_vld && w_sel_rsp_err));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_hs) begin
            if (w_mapped) begin
              r_sel   <= w_idx;
              r_state <= m_cmd_we ? ST_WR_WAIT : ST_RD_WAIT;
            end else if (!m_cmd_we) begin
              r_state <= ST_ERR_RSP;
            end
          end
        end
        ST_RD_WAIT: if (m_rsp_valid && m_rsp_ready) r_state <= ST_IDLE;
        ST_WR_WAIT: if (w_sel_rsp_vld) r_state <= ST_IDLE;
        ST_ERR_RSP: if (m_rsp_ready) r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_demux.sv
// Directed table-driven bench for bus_demux with 4 slaves; slave i returns rbase+i as read data.
module tb_bus_demux;
  localparam int SLV_N = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DW-1:0]        m_cmd_wdata;
  logic [AW-1:0]        m_cmd_addr;
  logic                 m_cmd_we;
  logic [3:0]           m_cmd_wem;
  logic                 m_cmd_valid;
  logic                 m_cmd_ready;
  logic [DW-1:0]        m_rsp_rdata;
  logic                 m_rsp_valid;
  logic                 m_rsp_ready;
  logic                 m_rsp_error;
  logic                 wr_err_o;
  logic [SLV_N*DW-1:0]  s_cmd_wdata;
  logic [SLV_N*AW-1:0]  s_cmd_addr;
  logic [SLV_N-1:0]     s_cmd_we;
  logic [SLV_N*4-1:0]   s_cmd_wem;
  logic [SLV_N-1:0]     s_cmd_valid;
  logic [SLV_N-1:0]     s_cmd_ready;
  logic [SLV_N*DW-1:0]  s_rsp_rdata;
  logic [SLV_N-1:0]     s_rsp_valid;
  logic [SLV_N-1:0]     s_rsp_ready;
  logic [SLV_N-1:0]     s_rsp_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_demux #(.SLV_N(SLV_N), .AW(AW), .DW(DW), .SEL_HI(31), .SEL_LO(28)) dut (
    .clk(clk), .rst(rst),
    .m_cmd_wdata(m_cmd_wdata), .m_cmd_addr(m_cmd_addr), .m_cmd_we(m_cmd_we),
    .m_cmd_wem(m_cmd_wem), .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_rsp_rdata(m_rsp_rdata), .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .m_rsp_error(m_rsp_error), .wr_err_o(wr_err_o),
    .s_cmd_wdata(s_cmd_wdata), .s_cmd_addr(s_cmd_addr), .s_cmd_we(s_cmd_we),
    .s_cmd_wem(s_cmd_wem), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_rsp_rdata(s_rsp_rdata), .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
    .s_rsp_error(s_rsp_error)
  );

  typedef struct {
    logic        cv;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wem;
    logic        mrr;
    logic [3:0]  scr;
    logic [3:0]  srv;
    logic [3:0]  sre;
    logic [31:0] rbase;
    logic        e_cr;
    logic [3:0]  e_scv;
    logic [3:0]  e_srr;
    logic        e_rv;
    logic        e_re;
    logic [31:0] e_rd;
    logic        e_we;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic cv, logic [31:0] addr, logic we, logic [3:0] wem,
                              logic mrr, logic [3:0] scr, logic [3:0] srv, logic [3:0] sre,
                              logic [31:0] rbase, logic e_cr, logic [3:0] e_scv,
                              logic [3:0] e_srr, logic e_rv, logic e_re,
                              logic [31:0] e_rd, logic e_we);
    vec_t v;
    v.cv = cv; v.addr = addr; v.we = we; v.wem = wem; v.mrr = mrr; v.scr = scr;
    v.srv = srv; v.sre = sre; v.rbase = rbase; v.e_cr = e_cr; v.e_scv = e_scv;
    v.e_srr = e_srr; v.e_rv = e_rv; v.e_re = e_re; v.e_rd = e_rd; v.e_we = e_we;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input int k);
    m_cmd_valid = v.cv;
    m_cmd_addr  = v.addr;
    m_cmd_we    = v.we;
    m_cmd_wem   = v.wem;
    m_cmd_wdata = 32'hC0DE_0000 + 32'(k);
    m_rsp_ready = v.mrr;
    s_cmd_ready = v.scr;
    s_rsp_valid = v.srv;
    s_rsp_error = v.sre;
    for (int i = 0; i < SLV_N; i++) s_rsp_rdata[i*DW +: DW] = v.rbase + 32'(i);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 32'h0, 0, 4'h0, 1, 4'hF, 4'h0, 4'h0, 32'h0, 1, 4'h0, 4'h0, 0, 0, 32'h0, 0);

    // Read slave 1, response two cycles after the handshake
    vecs.push_back(idle);
    vecs.push_back(mk(1, 32'h1000_0010, 0, 4'hF, 1, 4'hF, 4'h0, 4'h0, 32'h0, 1, 4'h2, 4'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 4'h0, 1, 4'hF, 4'h0, 4'h0, 32'h0, 0, 4'h0, 4'h2, 0, 0, 32'h1, 0));
    vecs.push_back(mk(0, 32'h0, 0, 4'h0, 1, 4'hF, 4'h2, 4'h0, 32'hDEAD_BEEE, 0, 4'h0, 4'h2, 1, 0, 32'hDEAD_BEEF, 0));
    vecs.push_back(idle);
    // Write slave 2 stalled three cycles, then a back-to-back read stalls behind it
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 32'h2000_0004, 1, 4'h3, 1, 4'hB, 4'h0, 4'h0, 32'h0, 0, 4'h4, 4'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(1, 32'h2000_0004, 1, 4'h3, 1, 4'hF, 4'h0, 4'h0, 32'h0, 1, 4'h4, 4'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 4'h0, 1, 4'hF, 4'h0, 4'h0, 32'h0, 0, 4'h0, 4'h4, 0, 0, 32'h0, 0));
    vecs.push_back(mk(1, 32'h0, 0, 4'hF, 1, 4'hF, 4'h4, 4'h0, 32'h0, 0, 4'h0, 4'h4, 0, 0, 32'h0, 0));
    vecs.push_back(mk(1, 32'h0, 0, 4'hF, 1, 4'hF, 4'h0, 4'h0, 32'h0, 1, 4'h1, 4'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 4'h0, 1, 4'hF, 4'h1, 4'h0, 32'h1234_0000, 0, 4'h0, 4'h1, 1, 0, 32'h1234_0000, 0));
    // Unmapped read: error response held until the master takes it
    vecs.push_back(mk(1, 32'h5000_0000, 0, 4'hF, 1, 4'h0, 4'h0, 4'h0, 32'h0, 1, 4'h0, 4'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 4'h0, 0, 4'hF, 4'hF, 4'h0, 32'hAAAA_0000, 0, 4'h0, 4'h0, 1, 1, 32'h0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 4'h0, 1, 4'hF, 4'hF, 4'h0, 32'hAAAA_0000, 0, 4'h0, 4'h0, 1, 1, 32'h0, 0));
    // Unmapped write pulses the error, next command accepted right after
    vecs.push_back(mk(1, 32'hF000_0000, 1, 4'hF, 1, 4'hF, 4'h0, 4'h0, 32'h0, 1, 4'h0, 4'h0, 0, 0, 32'h0, 1));
    vecs.push_back(mk(1, 32'h3000_0000, 0, 4'hF, 1, 4'hF, 4'h0, 4'h0, 32'h0, 1, 4'h8, 4'h0, 0, 0, 32'h0, 0));
    // Spurious slave-0 responses during the slave-3 read
    vecs.push_back(mk(0, 32'h0, 0, 4'h0, 1, 4'hF, 4'h1, 4'h0, 32'h5555_0000, 0, 4'h0, 4'h8, 0, 0, 32'h5555_0003, 0));
    vecs.push_back(mk(0, 32'h0, 0, 4'h0, 1, 4'hF, 4'h9, 4'h0, 32'h7777_0000, 0, 4'h0, 4'h8, 1, 0, 32'h7777_0003, 0));
    // Write to slave 1 that comes back with an error
    vecs.push_back(mk(1, 32'h1000_0000, 1, 4'h5, 1, 4'hF, 4'h0, 4'h0, 32'h0, 1, 4'h2, 4'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 4'h0, 1, 4'hF, 4'h2, 4'h2, 32'h0, 0, 4'h0, 4'h2, 0, 0, 32'h0, 1));
    vecs.push_back(idle);
    // Read error from slave 2, master back-pressures one cycle
    vecs.push_back(mk(1, 32'h2000_0000, 0, 4'hF, 1, 4'hF, 4'h0, 4'h0, 32'h0, 1, 4'h4, 4'h0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 4'h0, 0, 4'hF, 4'h4, 4'h4, 32'h0, 0, 4'h0, 4'h0, 1, 1, 32'h2, 0));
    vecs.push_back(mk(0, 32'h0, 0, 4'h0, 1, 4'hF, 4'h4, 4'h4, 32'h0, 0, 4'h0, 4'h4, 1, 1, 32'h2, 0));
    vecs.push_back(idle);

    // Reset with an unmapped write presented
    rst = 1'b1;
    drive(mk(1, 32'hF000_0000, 1, 4'hF, 1, 4'hF, 4'h0, 4'h0, 32'h0, 0, 4'h0, 4'h0, 0, 0, 32'h0, 0), 0);
    step();
    step();
    #2;
    chk("rst_cmd_ready", 128'(m_cmd_ready), 128'(1'b1));
    chk("rst_s_cmd_valid", 128'(s_cmd_valid), 128'(4'h0));
    chk("rst_s_rsp_ready", 128'(s_rsp_ready), 128'(4'h0));
    chk("rst_m_rsp_valid", 128'(m_rsp_valid), 128'(1'b0));
    chk("rst_wr_err", 128'(wr_err_o), 128'(1'b0));
    step();
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k], k);
      #2;
      chk($sformatf("v%0d_cmd_ready", k), 128'(m_cmd_ready), 128'(vecs[k].e_cr));
      chk($sformatf("v%0d_s_cmd_valid", k), 128'(s_cmd_valid), 128'(vecs[k].e_scv));
      chk($sformatf("v%0d_s_rsp_ready", k), 128'(s_rsp_ready), 128'(vecs[k].e_srr));
      chk($sformatf("v%0d_rsp_valid", k), 128'(m_rsp_valid), 128'(vecs[k].e_rv));
      chk($sformatf("v%0d_rsp_error", k), 128'(m_rsp_error), 128'(vecs[k].e_re));
      chk($sformatf("v%0d_rsp_rdata", k), 128'(m_rsp_rdata), 128'(vecs[k].e_rd));
      chk($sformatf("v%0d_wr_err", k), 128'(wr_err_o), 128'(vecs[k].e_we));
      chk($sformatf("v%0d_wem_bcast", k), 128'(s_cmd_wem), 128'({4{vecs[k].wem}}));
      chk($sformatf("v%0d_addr_bcast", k), 128'(s_cmd_addr), {4{vecs[k].addr}});
      chk($sformatf("v%0d_we_bcast", k), 128'(s_cmd_we), 128'({4{vecs[k].we}}));
      step();
    end

    // Reset while a read to slave 1 is pending drops it
    drive(mk(1, 32'h1000_0000, 0, 4'hF, 1, 4'hF, 4'h0, 4'h0, 32'h0, 0, 4'h0, 4'h0, 0, 0, 32'h0, 0), 0);
    #2;
    chk("pre_rst_hs", 128'(s_cmd_valid), 128'(4'h2));
    step();
    rst = 1'b1;
    drive(mk(0, 32'h0, 0, 4'h0, 1, 4'hF, 4'h2, 4'h0, 32'h0, 0, 4'h0, 4'h0, 0, 0, 32'h0, 0), 0);
    #2;
    chk("rdwait_rsp_valid", 128'(m_rsp_valid), 128'(1'b1));
    step();
    rst = 1'b0;
    #2;
    chk("post_rst_rsp_valid", 128'(m_rsp_valid), 128'(1'b0));
    chk("post_rst_s_rsp_ready", 128'(s_rsp_ready), 128'(4'h0));
    chk("post_rst_s_cmd_valid", 128'(s_cmd_valid), 128'(4'h0));
    chk("post_rst_cmd_ready", 128'(m_cmd_ready), 128'(1'b1));
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
